// File: rtl/sprite_plotter_if.sv
// Bus between the sprite plotter, its controller/ROM side (master) and the plotter itself (slave).
// Groups the draw request, the image-ROM port and the VGA pixel-write port.
interface sprite_plotter_if;
  logic        start;
  logic        fullScreen;
  logic        black;
  logic [7:0]  xInit;
  logic [6:0]  yInit;
  logic [14:0] romAddr;
  logic [2:0]  romColor;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport master (
    output start, fullScreen, black, xInit, yInit, romColor,
    input  romAddr, x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, fullScreen, black, xInit, yInit, romColor,
    output romAddr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/sprite_plotter.sv
// Sprite/full-screen plotter: scans a rectangle column-major, fetches one ROM colour per pixel
// and emits clipped x/y/colour/plot writes to the VGA adapter, then pulses done.
//
//   state | meaning
//   IDLE  | waiting for start; latches origin/mode on an accepted start
//   SCAN  | one ROM address per cycle, previous pixel emitted on the output stage
//   FLUSH | last pixel emitted, no new address
//   DONE  | one-cycle done pulse, then back to IDLE
module sprite_plotter #(
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic             clk,
  input logic             reset,
  sprite_plotter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  localparam logic [7:0] SPR_C_LAST  = 8'(SPRITE_W - 1);
  localparam logic [6:0] SPR_R_LAST  = 7'(SPRITE_H - 1);
  localparam logic [7:0] FULL_C_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] FULL_R_LAST = 7'(SCREEN_H - 1);

  state_t      state, stateNext;
  logic        fullL, blackL;
  logic [7:0]  xL;
  logic [6:0]  yL;
  logic [7:0]  c;
  logic [6:0]  r;
  logic [7:0]  cLast;
  logic [6:0]  rLast;
  logic        lastPix;
  logic [8:0]  xSum;
  logic [7:0]  ySum;
  logic        inScreen;
  logic [2:0]  colourHold;

  assign cLast   = fullL ? FULL_C_LAST : SPR_C_LAST;
  assign rLast   = fullL ? FULL_R_LAST : SPR_R_LAST;
  assign lastPix = (c == cLast) && (r == rLast);

  // Widened sums so off-screen pixels are clipped instead of wrapping onto the screen.
  assign xSum     = {1'b0, (fullL ? 8'd0 : xL)} + {1'b0, c};
  assign ySum     = {1'b0, (fullL ? 7'd0 : yL)} + {1'b0, r};
  assign inScreen = (xSum < 9'(SCREEN_W)) && (ySum < 8'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = SCAN;
      SCAN:    if (lastPix) stateNext = FLUSH;
      FLUSH:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ROM data arrives in the plot cycle, so colour passes straight through while plotting
  // and otherwise shows the last plotted colour.
  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done   = (state == DONE);
    bus.colour = bus.plot ? (blackL ? 3'b000 : bus.romColor) : colourHold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fullL       <= 1'b0;
      blackL      <= 1'b0;
      xL          <= '0;
      yL          <= '0;
      c           <= '0;
      r           <= '0;
      bus.romAddr <= '0;
      bus.x       <= '0;
      bus.y       <= '0;
      bus.plot    <= 1'b0;
      colourHold  <= '0;
    end else begin
      bus.plot <= 1'b0;
      if (bus.plot) colourHold <= blackL ? 3'b000 : bus.romColor;
      case (state)
        IDLE: begin
          if (bus.start) begin
            fullL       <= bus.fullScreen;
            blackL      <= bus.black;
            xL          <= bus.xInit;
            yL          <= bus.yInit;
            c           <= '0;
            r           <= '0;
            bus.romAddr <= '0;
          end
        end
        SCAN: begin
          bus.x    <= xSum[7:0];
          bus.y    <= ySum[6:0];
          bus.plot <= inScreen;
          if (!lastPix) begin
            bus.romAddr <= bus.romAddr + 15'd1;
            if (r == rLast) begin
              r <= '0;
              c <= c + 8'd1;
            end else begin
              r <= r + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: randomized scans compared against a per-pixel
// reference list built from the scan rules (column-major order, origin offset, clipping).
module tb_sprite_plotter;
  localparam int SW = 40;
  localparam int SH = 40;

  typedef struct {
    int         t;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sprite_plotter_if bus();

  sprite_plotter #(
    .SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  pix_t  expPlots[$];
  pix_t  obsPlots[$];
  int    obsAddr[$];
  logic  obsBusy[$];
  int    doneTs[$];
  int    checks = 0;
  int    errors = 0;
  int    plotErrs, addrErrs, busyErrs;
  string firstBad;

  logic       romFixedEn = 1'b0;
  logic [2:0] romFixed = 3'b000;
  logic [2:0] romSeed = 3'b000;

  // Image ROM with one cycle of read latency
  always @(posedge clk)
    bus.romColor <= romFixedEn ? romFixed : (bus.romAddr[2:0] ^ romSeed);

  task automatic build_model(input logic fs, input logic blk, input logic [7:0] xi,
                             input logic [6:0] yi, output int n);
    int w, h, ox, oy;
    pix_t p;
    w  = fs ? 160 : SW;
    h  = fs ? 120 : SH;
    ox = fs ? 0 : int'(xi);
    oy = fs ? 0 : int'(yi);
    expPlots.delete();
    for (int col = 0; col < w; col++)
      for (int row = 0; row < h; row++) begin
        int idx, px, py;
        idx = col * h + row;
        px = ox + col;
        py = oy + row;
        if (px < 160 && py < 120) begin
          p.t = 2 + idx;
          p.x = 8'(px);
          p.y = 7'(py);
          p.c = blk ? 3'b000 : (romFixedEn ? romFixed : (3'(idx) ^ romSeed));
          expPlots.push_back(p);
        end
      end
    n = w * h;
  endtask

  task automatic run_scan(input logic fs, input logic blk, input logic [7:0] xi,
                          input logic [6:0] yi, input int n, input int againA,
                          input int againB, input int stopAt);
    int limit;
    pix_t p;
    obsPlots.delete();
    obsAddr.delete();
    obsBusy.delete();
    doneTs.delete();
    limit = (stopAt > 0) ? stopAt : n + 3;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.fullScreen = fs;
    bus.black      = blk;
    bus.xInit      = xi;
    bus.yInit      = yi;
    @(posedge clk);
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      obsAddr.push_back(int'(bus.romAddr));
      obsBusy.push_back(bus.busy);
      if (bus.done === 1'b1) doneTs.push_back(t);
      if (bus.plot === 1'b1) begin
        p.t = t;
        p.x = bus.x;
        p.y = bus.y;
        p.c = bus.colour;
        obsPlots.push_back(p);
      end
      bus.start      = (t == againA) || (t == againB);
      bus.fullScreen = 1'($urandom);
      bus.black      = 1'($urandom);
      bus.xInit      = 8'($urandom);
      bus.yInit      = 7'($urandom);
    end
    bus.start = 1'b0;
  endtask

  task automatic score_scan(input int n);
    int m;
    plotErrs = 0;
    addrErrs = 0;
    busyErrs = 0;
    firstBad = "none";
    if (obsPlots.size() != expPlots.size()) plotErrs++;
    m = (obsPlots.size() < expPlots.size()) ? obsPlots.size() : expPlots.size();
    for (int i = 0; i < m; i++)
      if (obsPlots[i].t != expPlots[i].t || obsPlots[i].x !== expPlots[i].x ||
          obsPlots[i].y !== expPlots[i].y || obsPlots[i].c !== expPlots[i].c) begin
        if (plotErrs == 0)
          firstBad = $sformatf("plot %0d got t=%0d (%0d,%0d) c=%0d want t=%0d (%0d,%0d) c=%0d",
                               i, obsPlots[i].t, obsPlots[i].x, obsPlots[i].y, obsPlots[i].c,
                               expPlots[i].t, expPlots[i].x, expPlots[i].y, expPlots[i].c);
        plotErrs++;
      end
    for (int i = 0; i < obsAddr.size(); i++) begin
      int t;
      t = i + 1;
      if (obsAddr[i] != ((t <= n) ? t - 1 : n - 1)) addrErrs++;
      if (obsBusy[i] !== ((t <= n + 2) ? 1'b1 : 1'b0)) busyErrs++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b want 0", bus.plot); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.romAddr !== 15'd0) begin errors++; $display("FAIL reset_romAddr got %0d want 0", bus.romAddr); end
    checks++; if (bus.x !== 8'd0) begin errors++; $display("FAIL reset_x got %0d want 0", bus.x); end
    checks++; if (bus.y !== 7'd0) begin errors++; $display("FAIL reset_y got %0d want 0", bus.y); end
    checks++; if (bus.colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %0d want 0", bus.colour); end
    reset = 1'b0;
  endtask

  task automatic test_sprite();
    int n;
    romFixedEn = 1'b0; romSeed = 3'b000;
    build_model(1'b0, 1'b0, 8'd90, 7'd30, n);
    run_scan(1'b0, 1'b0, 8'd90, 7'd30, n, 0, 0, 0);
    score_scan(n);
    checks++; if (obsPlots.size() != 1600) begin errors++; $display("FAIL sprite_count got %0d want 1600", obsPlots.size()); end
    checks++; if (plotErrs != 0) begin errors++; $display("FAIL sprite_plots %0d bad, first: %s", plotErrs, firstBad); end
    checks++;
    if (obsPlots.size() < 1600 || obsPlots[0].x !== 8'd90 || obsPlots[0].y !== 7'd30 || obsPlots[0].t != 2) begin
      errors++; $display("FAIL sprite_first got size=%0d want (90,30) at t=2", obsPlots.size());
    end
    checks++;
    if (obsPlots.size() < 1600 || obsPlots[40].x !== 8'd91 || obsPlots[40].y !== 7'd30 || obsAddr[40] != 40) begin
      errors++; $display("FAIL sprite_plot40 got addr=%0d want (91,30) addr 40", obsAddr[40]);
    end
    checks++;
    if (obsPlots.size() < 1600 || obsPlots[1599].x !== 8'd129 || obsPlots[1599].y !== 7'd69 ||
        obsPlots[1599].c !== 3'b111) begin
      errors++; $display("FAIL sprite_last got size=%0d want (129,69) colour 7", obsPlots.size());
    end
    checks++; if (addrErrs != 0) begin errors++; $display("FAIL sprite_addr %0d bad cycles want 0", addrErrs); end
    checks++; if (busyErrs != 0) begin errors++; $display("FAIL sprite_busy %0d bad cycles want 0", busyErrs); end
    checks++;
    if (doneTs.size() != 1 || obsPlots.size() == 0 || doneTs[0] != obsPlots[obsPlots.size()-1].t + 1 ||
        doneTs[0] != n + 2) begin
      errors++; $display("FAIL sprite_done got %0d pulses first t=%0d want 1 at t=%0d",
                         doneTs.size(), (doneTs.size() > 0) ? doneTs[0] : -1, n + 2);
    end
  endtask

  task automatic test_clip();
    int n;
    romFixedEn = 1'b0; romSeed = 3'b010;
    build_model(1'b0, 1'b0, 8'd130, 7'd100, n);
    run_scan(1'b0, 1'b0, 8'd130, 7'd100, n, 0, 0, 0);
    score_scan(n);
    checks++; if (obsPlots.size() != 600) begin errors++; $display("FAIL clip_count got %0d want 600", obsPlots.size()); end
    checks++; if (plotErrs != 0) begin errors++; $display("FAIL clip_plots %0d bad, first: %s", plotErrs, firstBad); end
    checks++;
    if (doneTs.size() != 1 || doneTs[0] != 1602) begin
      errors++; $display("FAIL clip_done got %0d pulses first t=%0d want 1 at t=1602",
                         doneTs.size(), (doneTs.size() > 0) ? doneTs[0] : -1);
    end
  endtask

  task automatic test_full();
    int n;
    romFixedEn = 1'b0; romSeed = 3'b000;
    build_model(1'b1, 1'b0, 8'd50, 7'd0, n);
    run_scan(1'b1, 1'b0, 8'd50, 7'd0, n, 0, 0, 0);
    score_scan(n);
    checks++; if (obsPlots.size() != 19200) begin errors++; $display("FAIL full_count got %0d want 19200", obsPlots.size()); end
    checks++; if (plotErrs != 0) begin errors++; $display("FAIL full_plots %0d bad, first: %s", plotErrs, firstBad); end
    checks++;
    if (obsPlots.size() != 19200 || obsPlots[0].x !== 8'd0 || obsPlots[0].y !== 7'd0 ||
        obsPlots[19199].x !== 8'd159 || obsPlots[19199].y !== 7'd119 || obsAddr[19199] != 19199) begin
      errors++; $display("FAIL full_corners got size=%0d want (0,0)..(159,119) addr 19199", obsPlots.size());
    end
    checks++; if (addrErrs != 0) begin errors++; $display("FAIL full_addr %0d bad cycles want 0", addrErrs); end
    checks++;
    if (doneTs.size() != 1 || doneTs[0] != 19202) begin
      errors++; $display("FAIL full_done got %0d pulses first t=%0d want 1 at t=19202",
                         doneTs.size(), (doneTs.size() > 0) ? doneTs[0] : -1);
    end
  endtask

  task automatic test_black();
    int n;
    romFixedEn = 1'b1; romFixed = 3'b101;
    build_model(1'b0, 1'b1, 8'd0, 7'd0, n);
    run_scan(1'b0, 1'b1, 8'd0, 7'd0, n, 0, 0, 0);
    score_scan(n);
    romFixedEn = 1'b0;
    checks++; if (plotErrs != 0) begin errors++; $display("FAIL black_plots %0d bad, first: %s", plotErrs, firstBad); end
    checks++; if (addrErrs != 0) begin errors++; $display("FAIL black_addr %0d bad cycles want 0", addrErrs); end
  endtask

  task automatic test_start_busy();
    int n;
    romSeed = 3'b100;
    build_model(1'b0, 1'b0, 8'd10, 7'd20, n);
    // re-request at plot #500 and again in the done cycle
    run_scan(1'b0, 1'b0, 8'd10, 7'd20, n, 502, n + 2, 0);
    score_scan(n);
    checks++; if (obsPlots.size() != 1600) begin errors++; $display("FAIL busy_count got %0d want 1600", obsPlots.size()); end
    checks++; if (plotErrs != 0) begin errors++; $display("FAIL busy_plots %0d bad, first: %s", plotErrs, firstBad); end
    checks++; if (doneTs.size() != 1) begin errors++; $display("FAIL busy_done_pulses got %0d want 1", doneTs.size()); end
    checks++; if (busyErrs != 0) begin errors++; $display("FAIL busy_busy %0d bad cycles want 0", busyErrs); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_restart got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    romSeed = 3'b001;
    build_model(1'b0, 1'b0, 8'd20, 7'd10, n);
    run_scan(1'b0, 1'b0, 8'd20, 7'd10, n, 0, 0, 702);
    checks++; if (obsPlots.size() != 701) begin errors++; $display("FAIL rstmid_before got %0d want 701", obsPlots.size()); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL rstmid_plot got %b want 0", bus.plot); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.romAddr !== 15'd0) begin errors++; $display("FAIL rstmid_addr got %0d want 0", bus.romAddr); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.plot !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got plot=%b want 0", bus.plot); end
    build_model(1'b0, 1'b0, 8'd5, 7'd80, n);
    run_scan(1'b0, 1'b0, 8'd5, 7'd80, n, 0, 0, 0);
    score_scan(n);
    checks++; if (plotErrs != 0) begin errors++; $display("FAIL rstmid_fresh %0d bad, first: %s", plotErrs, firstBad); end
    checks++; if (addrErrs != 0) begin errors++; $display("FAIL rstmid_addr_fresh %0d bad cycles want 0", addrErrs); end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      int n;
      logic [7:0] xi;
      logic [6:0] yi;
      logic blk;
      xi = 8'($urandom_range(0, 255));
      yi = 7'($urandom_range(0, 127));
      blk = 1'($urandom);
      romSeed = 3'($urandom);
      build_model(1'b0, blk, xi, yi, n);
      run_scan(1'b0, blk, xi, yi, n, 0, 0, 0);
      score_scan(n);
      checks++;
      if (plotErrs != 0) begin
        errors++; $display("FAIL rand%0d_plots origin (%0d,%0d) %0d bad, first: %s", it, xi, yi, plotErrs, firstBad);
      end
      checks++;
      if (doneTs.size() != 1 || doneTs[0] != n + 2) begin
        errors++; $display("FAIL rand%0d_done got %0d pulses first t=%0d want 1 at t=%0d",
                           it, doneTs.size(), (doneTs.size() > 0) ? doneTs[0] : -1, n + 2);
      end
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.fullScreen = 1'b0;
    bus.black      = 1'b0;
    bus.xInit      = '0;
    bus.yInit      = '0;
    test_reset();
    test_sprite();
    test_clip();
    test_full();
    test_black();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
